enc_layer_sched: RTL
====================

// Module: enc_layer_sched
// PURPOSE
//  Two-requester scheduler that time-shares one batched encoder layer engine (x -> y = Wx+b, done_all).
//  Arbitrates requests round-robin, latches the winner's input vector and holds it stable for the whole run.
//  Sequences the engine's active-high sync reset, waits for done_all or timeout, returns y to the owner.
//  Sits between the feature front-ends and the shared encoder layer instance.
// PARAMETERS
//  BITSIZE   16   fixed-point word width
//  IN_SIZE   92   input vector length
//  OUT_SIZE  4    output vector length
//  TIMEOUT   64   max RUN cycles before aborting with error (>=2)
// PORTS
//  clk         in   1                  clock, all logic on rising edge
//  reset       in   1                  asynchronous, active-low reset
//  req0_valid  in   1                  requester 0 has a vector
//  req0_ready  out  1                  requester 0 accepted (transfer on valid&ready)
//  req0_x      in   BITSIZE*IN_SIZE    requester 0 input vector
//  rsp0_valid  out  1                  result for requester 0 available
//  rsp0_ready  in   1                  requester 0 takes result
//  rsp0_y      out  BITSIZE*OUT_SIZE   result vector
//  rsp0_err    out  1                  result invalid (timeout), rsp0_y is 0
//  req1_*/rsp1_*    same as requester 0
//  eng_reset   out  1                  engine sync reset, active-high
//  eng_x       out  BITSIZE*IN_SIZE    engine input, registered
//  eng_y       in   BITSIZE*OUT_SIZE   engine output
//  eng_done    in   1                  engine done_all
//  busy        out  1                  state != IDLE
//  owner       out  1                  requester currently served
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rr_ptr=0 (req0 has priority), eng_reset=1, eng_x=0, result/err regs=0,
//   all rsp*_valid=0, busy=0, owner=0, run counter=0. Assertion mid-run aborts silently, no response issued.
//  States: IDLE -> RUN -> RESP -> IDLE.
//  IDLE: eng_reset=1 (engine parked). Grant g = (req0&req1) ? rr_ptr : (req1 ? 1 : 0).
//   reqg_ready = (state==IDLE) && reqg_valid, combinational. Other ready=0.
//   On accept: eng_x<=reqg_x, owner<=g, rr_ptr<=~g, cnt<=0, state<=RUN.
//  RUN: eng_reset=0, eng_x held constant, cnt increments each cycle.
//   eng_done=1 -> res<=eng_y, err<=0, state<=RESP.
//   else cnt==TIMEOUT-1 -> res<=0, err<=1, state<=RESP. eng_done and timeout same cycle: done wins.
//  RESP: eng_reset=1; rsp[owner]_valid=1 with res/err held stable. Other rsp_valid=0.
//   rsp[owner]_ready=1 -> state<=IDLE. No new request accepted while in RESP.
//  eng_done outside RUN is ignored. RESP->IDLE->accept gives >=1 IDLE cycle, so engine sees >=1 reset edge.
//  Latency: rsp_valid rises exactly 1 cycle after the edge sampling eng_done=1.
//   Min accept-to-accept spacing = engine latency + 3 cycles.
//  Widths: cnt is $clog2(TIMEOUT) bits. No arithmetic on data; y passed unmodified.
//  rsp*_y/rsp*_err driven from res/err regardless of valid; consumers qualify with valid.
// TESTING (bench uses behavioural engine stub: done_all N cycles after reset release, y=f(x))
//  1 Single req0, stub N=5 -> req0_ready high 1 cycle; rsp0_valid 1 cycle after eng_done; rsp0_y=f(x0), err=0.
//  2 req0 and req1 valid together, repeatedly -> grants alternate 0,1,0,1; each rsp on its own port only.
//  3 Stub never raises done, TIMEOUT=64 -> rsp_valid after exactly 64 RUN cycles, err=1, y=0.
//  4 Hold rsp1_ready=0 for 10 cycles -> rsp1_valid/y stable; req0_ready stays 0 until RESP exits.
//  5 reset=0 asserted mid-RUN -> immediately eng_reset=1, busy=0, no rsp; after release req0 wins first.
//  6 Toggle req0_x while in RUN -> eng_x unchanged; result matches vector latched at accept.

Source files
------------

// File: rtl/enc_layer_sched.sv
// Purpose: round-robin scheduler sharing one encoder layer engine between two requesters.
// Latency: accept -> engine run -> rsp_valid the cycle after eng_done (or after TIMEOUT RUN cycles).
// Backpressure: req*_ready only in IDLE; RESP holds result until the owner's rsp_ready.
module enc_layer_sched #(
    parameter int BITSIZE  = 16,
    parameter int IN_SIZE  = 92,
    parameter int OUT_SIZE = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [BITSIZE*IN_SIZE-1:0]  req0_x,
    output logic                        rsp0_valid,
    input  logic                        rsp0_ready,
    output logic [BITSIZE*OUT_SIZE-1:0] rsp0_y,
    output logic                        rsp0_err,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [BITSIZE*IN_SIZE-1:0]  req1_x,
    output logic                        rsp1_valid,
    input  logic                        rsp1_ready,
    output logic [BITSIZE*OUT_SIZE-1:0] rsp1_y,
    output logic                        rsp1_err,
    output logic                        eng_reset,
    output logic [BITSIZE*IN_SIZE-1:0]  eng_x,
    input  logic [BITSIZE*OUT_SIZE-1:0] eng_y,
    input  logic                        eng_done,
    output logic                        busy,
    output logic                        owner
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t                        state, state_nxt;
    logic                          rr_ptr;
    logic                          grant;
    logic                          accept;
    logic [CW-1:0]                 cnt;
    logic [BITSIZE*OUT_SIZE-1:0]   res;
    logic                          err;

    // On contention the pointer decides; otherwise whoever is requesting wins.
    assign grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;

    assign eng_reset  = (state != RUN);
    assign busy       = (state != IDLE);
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_y     = res;
    assign rsp1_y     = res;
    assign rsp0_err   = err;
    assign rsp1_err   = err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (eng_done || (cnt == CNT_MAX)) state_nxt = RESP;
            RESP: if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
            owner  <= 1'b0;
            eng_x  <= '0;
            cnt    <= '0;
            res    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_x  <= grant ? req1_x : req0_x;
                        owner  <= grant;
                        rr_ptr <= ~grant;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // A done arriving on the timeout cycle still counts as success.
                    if (eng_done) begin
                        res <= eng_y;
                        err <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        res <= '0;
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
